peri_write_buffer: RTL



---
 rtl/peri_wbuf_pkg.sv | 24 ++
 rtl/peri_wbuf_fifo.sv | 76 +++++++
 rtl/peri_write_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/peri_wbuf_pkg.sv
// Shared types and helpers for the peripheral write buffer.
// Drain FSM encoding, entry layout and FIFO count-width helper.
package peri_wbuf_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_GAP     = 2'd2
   } drain_state_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wbuf_entry_t;

   // Count must represent 0..DEPTH inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/peri_wbuf_fifo.sv
// Synchronous FIFO for the peripheral write buffer.
// Ports: push_i/pop_i/coal_i control, push_addr_i/push_data_i in,
// head_addr_o/head_data_o (combinational head), tail_addr_o, count_o.
module peri_wbuf_fifo
   import peri_wbuf_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic                      coal_i,
   input  logic                      pop_i,
   input  logic [ADDR_W-1:0]         push_addr_i,
   input  logic [DATA_W-1:0]         push_data_i,
   output logic [ADDR_W-1:0]         head_addr_o,
   output logic [DATA_W-1:0]         head_data_o,
   output logic [ADDR_W-1:0]         tail_addr_o,
   output logic [cnt_w(DEPTH)-1:0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] tail_idx;

   assign tail_idx    = wptr_q - 1'b1;
   assign head_addr_o = addr_mem[rptr_q];
   assign head_data_o = data_mem[rptr_q];
   assign tail_addr_o = addr_mem[tail_idx];
   assign count_o     = cnt_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage carries no reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (push_i) begin
         addr_mem[wptr_q] <= push_addr_i;
         data_mem[wptr_q] <= push_data_i;
      end else if (coal_i) begin
         data_mem[tail_idx] <= push_data_i;
      end
   end

endmodule

// File: rtl/peri_write_buffer.sv
// Peripheral write buffer: queues core writes, drains to a valid/ready bus.
// Ports: peri_web/peri_addr/peri_datao in, bus_valid/bus_addr/bus_data out,
// bus_ready in, ovf_clr in, buf_count/buf_full/buf_empty/overflow status.
// Optional tail coalescing: define PERI_WBUF_COALESCE_EN.
module peri_write_buffer
   import peri_wbuf_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     peri_web,
   input  logic [ADDR_W-1:0]        peri_addr,
   input  logic [DATA_W-1:0]        peri_datao,
   output logic                     bus_valid,
   input  logic                     bus_ready,
   output logic [ADDR_W-1:0]        bus_addr,
   output logic [DATA_W-1:0]        bus_data,
   input  logic                     ovf_clr,
   output logic [cnt_w(DEPTH)-1:0]  buf_count,
   output logic                     buf_full,
   output logic                     buf_empty,
   output logic                     overflow
);

   localparam int CW = cnt_w(DEPTH);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES - 1);

   localparam logic [1:0] IDLE    = ST_IDLE;
   localparam logic [1:0] PRESENT = ST_PRESENT;
   localparam logic [1:0] GAP     = ST_GAP;

   logic [1:0]        state_q, state_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ovf_q, ovf_d;

   logic              push_req, push, pop, coal, drop;
   logic              fifo_empty, fifo_full;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] head_addr, tail_addr;
   logic [DATA_W-1:0] head_data;

   assign push_req   = ~peri_web;
   assign fifo_empty = (cnt == '0);
   assign fifo_full  = (cnt == CW'(DEPTH));

`ifdef PERI_WBUF_COALESCE_EN
   // Tail popped this edge is already headed for the output register.
   assign coal = push_req && !fifo_empty &&
                 (tail_addr == peri_addr) &&
                 !(pop && cnt == CW'(1));
`else
   logic unused_tail;
   assign unused_tail = ^tail_addr;
   assign coal = 1'b0;
`endif

   // A pop on the same edge frees a slot, so full+pop still accepts.
   assign push = push_req && !coal && (!fifo_full || pop);
   assign drop = push_req && !coal && fifo_full && !pop;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (bus_ready) begin
               if (GAP_CYCLES == 0) begin
                  if (!fifo_empty) pop = 1'b1;
                  else state_d = IDLE;
               end else begin
                  state_d = GAP;
                  gap_d   = GAP_INIT;
               end
            end
         end
         GAP: begin
            // Last gap cycle pops directly so the low time is exact.
            if (gap_q == '0) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = PRESENT;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         addr_d = head_addr;
         data_d = head_data;
      end
      valid_d = (state_d == PRESENT);
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gap_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   peri_wbuf_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .coal_i      (coal),
      .pop_i       (pop),
      .push_addr_i (peri_addr),
      .push_data_i (peri_datao),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .tail_addr_o (tail_addr),
      .count_o     (cnt)
   );

   assign bus_valid = valid_q;
   assign bus_addr  = addr_q;
   assign bus_data  = data_q;
   assign buf_count = cnt;
   assign buf_full  = fifo_full;
   assign buf_empty = fifo_empty && (state_q == IDLE);
   assign overflow  = ovf_q;

endmodule
